// File: rtl/lcd_fb_port_arbiter_if.sv
// rtl/lcd_fb_port_arbiter_if.sv - requester, control and BRAM signals of the frame-buffer port arbiter
interface lcd_fb_port_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 40,
  parameter int CNT_W  = 16
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              flush_req;
  logic              flush_done;
  logic              stall_clr;
  logic [CNT_W-1:0]  stall_cnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Requester/BRAM side (drives requests, read data from memory)
  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, flush_req, stall_clr, mem_dout,
    input  wr_ready, rd_ready, rd_valid, rd_data, flush_done, stall_cnt,
           mem_en, mem_we, mem_addr, mem_din
  );

  // Arbiter side
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, flush_req, stall_clr, mem_dout,
    output wr_ready, rd_ready, rd_valid, rd_data, flush_done, stall_cnt,
           mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/lcd_fb_port_arbiter.sv
// rtl/lcd_fb_port_arbiter.sv - single-port frame-buffer arbiter: display reads first, writes via FIFO
module lcd_fb_port_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic                  HCLK,
  input logic                  HRESET,
  lcd_fb_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_hold_q;
  logic              full, empty, push;
  logic              grant_wr, grant_rd, flush_done;

  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // wr_ready is held low during reset so nothing is accepted into a FIFO being cleared
  assign bus.wr_ready = !full && !HRESET;
  assign push         = bus.wr_valid && bus.wr_ready;

  // Grant selection and flush sequencing; one BRAM access per cycle
  always_comb begin
    state_d    = state_q;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    flush_done = 1'b0;
    if (!HRESET) begin
      case (state_q)
        ST_RUN: begin
          if (full)             grant_wr = 1'b1;
          else if (bus.rd_req)  grant_rd = 1'b1;
          else if (!empty)      grant_wr = 1'b1;
          if (bus.flush_req)    state_d  = ST_FLUSH;
        end
        ST_FLUSH: begin
          grant_wr = !empty;
          if (empty && !push) state_d = ST_DONE;
        end
        ST_DONE: begin
          flush_done = 1'b1;
          state_d    = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FIFO occupancy: push and pop together leave the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push, grant_wr})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Refused-read counter; clear has priority over the saturating increment
  always_comb begin
    stall_d = stall_q;
    if (bus.stall_clr)                              stall_d = '0;
    else if (bus.rd_req && !grant_rd && !(&stall_q)) stall_d = stall_q + 1'b1;
  end

  assign bus.mem_en     = grant_wr || grant_rd;
  assign bus.mem_we     = grant_wr;
  assign bus.mem_addr   = grant_wr ? fifo_addr_q[rd_ptr_q] : (grant_rd ? bus.rd_addr : '0);
  assign bus.mem_din    = grant_wr ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.rd_ready   = grant_rd;
  assign bus.flush_done = flush_done;
  assign bus.stall_cnt  = stall_q;
  assign bus.rd_valid   = rd_valid_q;
  // BRAM output is already registered, so it is passed straight through in the valid cycle
  assign bus.rd_data    = rd_valid_q ? bus.mem_dout : rd_hold_q;

  // Control state; reset drops queued writes and any read in flight
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      rd_valid_q <= grant_rd;
      if (push)       wr_ptr_q  <= wr_ptr_q + 1'b1;
      if (grant_wr)   rd_ptr_q  <= rd_ptr_q + 1'b1;
      if (rd_valid_q) rd_hold_q <= bus.mem_dout;
    end
  end

  // FIFO storage; contents are only meaningful under the valid count, so no reset
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
      fifo_data_q[wr_ptr_q] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_lcd_fb_port_arbiter.sv
// tb/tb_lcd_fb_port_arbiter.sv - self-checking bench for lcd_fb_port_arbiter
module tb_lcd_fb_port_arbiter;
  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 40;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 4;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b0;
  always #5 HCLK = ~HCLK;

  lcd_fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  lcd_fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
  } rd_exp_t;

  typedef struct {
    logic rd, wv, fl, sc;
    logic rr, wr, en, we, fd;
    logic             cs;
    logic [CNT_W-1:0] st;
  } vec_t;

  wr_exp_t           wr_q[$];
  rd_exp_t           rd_q[$];
  vec_t              vt[$];
  int                checks = 0;
  int                errors = 0;
  int                cyc    = 0;
  int                wa     = 0;
  logic [DATA_W-1:0] last_rd = '0;
  wr_exp_t           mon_w;
  rd_exp_t           mon_r;

  function automatic logic [DATA_W-1:0] rd_pattern(input logic [ADDR_W-1:0] a);
    return {a ^ 18'h2AAAA, 22'h3C0F0F};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // BRAM model: read-only pattern region, registered output
  always @(posedge HCLK) begin
    cyc = cyc + 1;
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) bus.mem_dout <= rd_pattern(bus.mem_addr);
  end

  // Scoreboard: BRAM writes in push order, read data one cycle after each grant
  always @(negedge HCLK) begin
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with none queued", bus.mem_addr, bus.mem_din);
      end else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(mon_w.addr));
        chk("wr_data", 64'(bus.mem_din), 64'(mon_w.data));
      end
    end
    if (bus.rd_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: data %0h with no grant pending", bus.rd_data);
      end else begin
        mon_r = rd_q.pop_front();
        chk("rd_latency", 64'(cyc - mon_r.cyc), 64'd1);
        chk("rd_data", 64'(bus.rd_data), 64'(rd_pattern(mon_r.addr)));
        last_rd = rd_pattern(mon_r.addr);
      end
    end else begin
      chk("rd_data_hold", 64'(bus.rd_data), 64'(last_rd));
    end
    if (bus.rd_ready === 1'b1) begin
      mon_r.cyc  = cyc;
      mon_r.addr = bus.rd_addr;
      rd_q.push_back(mon_r);
    end
  end

  task automatic drive(input logic rd, input logic wv, input logic fl, input logic sc);
    wr_exp_t e;
    bus.rd_req    = rd;
    bus.rd_addr   = 18'h80 + 18'(cyc & 127);
    bus.wr_valid  = wv;
    bus.wr_addr   = 18'(wa);
    bus.wr_data   = 40'hA0 + 40'(wa);
    bus.flush_req = fl;
    bus.stall_clr = sc;
    if (wv) begin
      e.addr = bus.wr_addr;
      e.data = bus.wr_data;
      wr_q.push_back(e);
      wa++;
    end
  endtask

  task automatic v(input logic rd, input logic wv, input logic fl, input logic sc,
                   input logic rr, input logic wr, input logic en, input logic we,
                   input logic fd, input logic cs, input int st);
    vec_t t;
    t.rd = rd; t.wv = wv; t.fl = fl; t.sc = sc;
    t.rr = rr; t.wr = wr; t.en = en; t.we = we; t.fd = fd;
    t.cs = cs; t.st = CNT_W'(st);
    vt.push_back(t);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1 HRESET = 1'b1;
    #2;
    chk("reset_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("reset_mem_en", 64'(bus.mem_en), 64'd0);
    chk("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("reset_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("reset_flush_done", 64'(bus.flush_done), 64'd0);
    chk("reset_rd_data", 64'(bus.rd_data), 64'd0);
    @(posedge HCLK); #1 HRESET = 1'b0;
    #3 chk("release_wr_ready", 64'(bus.wr_ready), 64'd1);

    //  rd wv fl sc | rr wr en we fd | cs st
    // write-only: addr 0..3, one BRAM write per cycle from the cycle after the first accept
    v(0,1,0,0, 0,1,0,0,0, 1,0);
    v(0,1,0,0, 0,1,1,1,0, 0,0);
    v(0,1,0,0, 0,1,1,1,0, 0,0);
    v(0,1,0,0, 0,1,1,1,0, 0,0);
    v(0,0,0,0, 0,1,1,1,0, 0,0);
    v(0,0,0,0, 0,1,0,0,0, 1,0);
    // read priority: reads win until full, then one forced write
    v(1,1,0,1, 1,1,1,0,0, 1,0);
    v(1,1,0,0, 1,1,1,0,0, 0,0);
    v(1,1,0,0, 1,1,1,0,0, 0,0);
    v(1,1,0,0, 1,1,1,0,0, 0,0);
    v(1,0,0,0, 0,0,1,1,0, 1,0);
    v(1,0,0,0, 1,1,1,0,0, 1,1);
    v(0,0,0,0, 0,1,1,1,0, 1,1);
    v(0,0,0,0, 0,1,1,1,0, 0,0);
    v(0,0,0,0, 0,1,1,1,0, 0,0);
    v(0,0,0,0, 0,1,0,0,0, 1,1);
    // flush with 3 queued, extra flush_req in FLUSH and DONE ignored
    v(1,1,0,1, 1,1,1,0,0, 0,0);
    v(1,1,0,0, 1,1,1,0,0, 0,0);
    v(1,1,0,0, 1,1,1,0,0, 0,0);
    v(1,0,1,0, 1,1,1,0,0, 1,0);
    v(1,0,0,0, 0,1,1,1,0, 1,0);
    v(1,0,1,0, 0,1,1,1,0, 1,1);
    v(1,0,0,0, 0,1,1,1,0, 1,2);
    v(1,0,0,0, 0,1,0,0,0, 1,3);
    v(1,0,1,0, 0,1,0,0,1, 1,4);
    v(1,0,0,0, 1,1,1,0,0, 1,5);
    v(0,0,0,0, 0,1,0,0,0, 1,5);

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge HCLK); #1;
      drive(vt[i].rd, vt[i].wv, vt[i].fl, vt[i].sc);
      #3;
      chk($sformatf("v%0d_rd_ready", i), 64'(bus.rd_ready), 64'(vt[i].rr));
      chk($sformatf("v%0d_wr_ready", i), 64'(bus.wr_ready), 64'(vt[i].wr));
      chk($sformatf("v%0d_mem_en", i), 64'(bus.mem_en), 64'(vt[i].en));
      chk($sformatf("v%0d_mem_we", i), 64'(bus.mem_we), 64'(vt[i].we));
      chk($sformatf("v%0d_flush_done", i), 64'(bus.flush_done), 64'(vt[i].fd));
      if (vt[i].cs) chk($sformatf("v%0d_stall_cnt", i), 64'(bus.stall_cnt), 64'(vt[i].st));
    end

    // saturation: flush kept busy by a push every cycle refuses 20 reads
    @(posedge HCLK); #1; drive(1'b1, 1'b1, 1'b1, 1'b1);
    #3 chk("sat_start_rd_ready", 64'(bus.rd_ready), 64'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge HCLK); #1; drive(1'b1, 1'b1, 1'b0, 1'b0);
      #3;
      chk($sformatf("sat%0d_stall_cnt", k), 64'(bus.stall_cnt), 64'((k - 1 > 15) ? 15 : k - 1));
      chk($sformatf("sat%0d_rd_ready", k), 64'(bus.rd_ready), 64'd0);
      chk($sformatf("sat%0d_mem_we", k), 64'(bus.mem_we), 64'd1);
    end
    @(posedge HCLK); #1; drive(1'b1, 1'b0, 1'b0, 1'b1);
    #3 chk("sat_final_stall_cnt", 64'(bus.stall_cnt), 64'd15);
    @(posedge HCLK); #1; drive(1'b0, 1'b0, 1'b0, 1'b0);
    #3 chk("sat_clr_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("sat_drained_mem_en", 64'(bus.mem_en), 64'd0);
    @(posedge HCLK); #3 chk("sat_flush_done", 64'(bus.flush_done), 64'd1);
    @(posedge HCLK); #3 chk("sat_flush_done_end", 64'(bus.flush_done), 64'd0);

    // reset mid-burst with 3 entries queued and a read in flight
    for (int k = 0; k < 3; k++) begin
      @(posedge HCLK); #1; drive(1'b1, 1'b1, 1'b0, 1'b0);
      #3 chk($sformatf("burst%0d_rd_ready", k), 64'(bus.rd_ready), 64'd1);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    wr_q.delete();
    rd_q.delete();
    last_rd = '0;
    bus.rd_req   = 1'b1;
    bus.wr_valid = 1'b1;
    #3;
    chk("midrst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("midrst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("midrst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("midrst_rd_ready", 64'(bus.rd_ready), 64'd0);
    chk("midrst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("postrst_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("postrst_mem_en", 64'(bus.mem_en), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge HCLK); #3;
      chk($sformatf("postrst%0d_mem_en", k), 64'(bus.mem_en), 64'd0);
      chk($sformatf("postrst%0d_rd_valid", k), 64'(bus.rd_valid), 64'd0);
    end

    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
